control_divisor: RTL and testbench
==================================

Name: control_divisor

Overview:
- Sequencer for the 64-bit byte divisor feeding the 5x5 kernel window.
- Fetches 8-pixel words from the line source over a valid/ready handshake and holds each word stable on datos.
- Steps the divisor's 2-bit seleccion through 0..3, presenting four 5-byte windows per word to the kernel over a second valid/ready handshake.
- Counts words per row and rows per image, and flags row and image completion.

Parameters:
PALABRAS_POR_FILA, 2, 64-bit words per image row (>=1); each word yields 4 windows.
FILAS, 4, rows per image (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset_n  input  1  asynchronous, active-low reset.
iniciar  input  1  one-cycle start pulse; only honoured in REPOSO.
palabra_valida  input  1  source has a word on palabra.
palabra  input  64  source word; byte [63:56] is the leftmost pixel.
palabra_lista  output  1  controller accepts palabra this cycle.
datos  output  64  registered word driven to the divisor datos input.
seleccion  output  2  divisor window select.
ventana_valida  output  1  divisor outputs hold a valid window.
ventana_lista  input  1  kernel accepts the current window.
fin_fila  output  1  one-cycle pulse: last window of a row accepted.
fin_imagen  output  1  one-cycle pulse: last window of the image accepted.
ocupado  output  1  high in every state except REPOSO.

Behaviour:
- Reset: state REPOSO; datos=0, seleccion=0, palabra_lista=0, ventana_valida=0, fin_fila=0, fin_imagen=0, ocupado=0; word and row counters=0.
- Reset asserted mid-operation aborts immediately to the reset values. The in-flight word is discarded and no fin pulse is produced.
- State REPOSO:
  - iniciar=1 -> CARGA; counters cleared.
  - Any other input is ignored.
- State CARGA:
  - palabra_lista=1 (decoded from state).
  - On palabra_valida&palabra_lista: datos<=palabra, seleccion<=0, go to EMITE.
  - Without palabra_valida, remain in CARGA indefinitely.
- State EMITE:
  - ventana_valida=1 (decoded from state); datos and seleccion are held stable until accepted.
  - On ventana_lista with seleccion<3: seleccion increments and the state stays EMITE.
  - On ventana_lista with seleccion==3 (word exhausted), the word counter advances:
    - Not the last word of the row -> CARGA.
    - Last word of the row, not the last row -> word counter=0, row counter+1, fin_fila pulses the next cycle, -> CARGA.
    - Last word of the last row -> fin_fila and fin_imagen both pulse the next cycle, -> REPOSO.
- Latency and throughput:
  - Word accepted in cycle N -> first window valid in cycle N+1.
  - With both sides always ready, throughput is 4 windows per 5 cycles; there is no prefetch.
- Handshake rules:
  - ventana_valida never drops without acceptance.
  - palabra_lista and ventana_valida are never high in the same cycle.
- iniciar outside REPOSO has no effect.
- fin_fila and fin_imagen are registered single-cycle pulses and are low in every other cycle.
- seleccion never exceeds 3. It wraps to 0 only by loading a new word, never by incrementing.
- Counter widths: clog2 of the respective parameter, minimum 1 bit. Terminal compares use PALABRAS_POR_FILA-1 and FILAS-1.

Test Plan:
1. Reset then idle -> all outputs 0, ocupado=0. Assert reset_n=0 during EMITE at seleccion=2 -> next-edge values all 0, state REPOSO.
2. iniciar, source always valid with words 0x0001020304050607, 0x08090A0B0C0D0E0F, sink always ready (defaults):
   - Windows seen with seleccion 0,1,2,3 per word and datos stable per word.
   - palabra_lista high exactly one cycle every 5.
   - fin_fila after the 8th window.
   - Image completes after 32 windows, with fin_imagen and fin_fila together exactly once, then ocupado=0.
3. Sink backpressure: ventana_lista low 3 cycles at seleccion=1 -> seleccion and datos unchanged and ventana_valida stays 1; release -> seleccion=2 next cycle.
4. Source starvation: palabra_valida low 5 cycles in CARGA -> palabra_lista held 1, ventana_valida 0, no counter change. Word arrives -> ventana_valida next cycle with seleccion=0.
5. iniciar pulsed during EMITE and during CARGA -> no change to counters, state or outputs. iniciar after fin_imagen -> new image starts with counters at 0.
6. PALABRAS_POR_FILA=1, FILAS=1 -> 4 windows, then fin_fila and fin_imagen in the same cycle, then REPOSO.

Source files
------------

// File: rtl/control_divisor.sv
// ============================================================================
// Module      : control_divisor
// Description : Sequencer that fetches 64-bit pixel words and steps the byte
//               divisor through four 5-byte windows per word, with row/image
//               completion pulses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module control_divisor #(
    parameter int PALABRAS_POR_FILA = 2,
    parameter int FILAS             = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        iniciar,
    input  logic        palabra_valida,
    input  logic [63:0] palabra,
    output logic        palabra_lista,
    output logic [63:0] datos,
    output logic [1:0]  seleccion,
    output logic        ventana_valida,
    input  logic        ventana_lista,
    output logic        fin_fila,
    output logic        fin_imagen,
    output logic        ocupado
);

    localparam int PW = (PALABRAS_POR_FILA > 1) ? $clog2(PALABRAS_POR_FILA) : 1;
    localparam int FW = (FILAS > 1) ? $clog2(FILAS) : 1;
    localparam logic [PW-1:0] C_ULT_PAL  = PW'(PALABRAS_POR_FILA - 1);
    localparam logic [FW-1:0] C_ULT_FILA = FW'(FILAS - 1);

    localparam logic [1:0] REPOSO = 2'd0;
    localparam logic [1:0] CARGA  = 2'd1;
    localparam logic [1:0] EMITE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [63:0]   datos_q, datos_d;
    logic [1:0]    sel_q, sel_d;
    logic [PW-1:0] pal_q, pal_d;
    logic [FW-1:0] fila_q, fila_d;
    logic          fin_fila_q, fin_fila_d;
    logic          fin_imagen_q, fin_imagen_d;

    always_comb begin
        state_d      = state_q;
        datos_d      = datos_q;
        sel_d        = sel_q;
        pal_d        = pal_q;
        fila_d       = fila_q;
        fin_fila_d   = 1'b0;
        fin_imagen_d = 1'b0;
        case (state_q)
            REPOSO: begin
                if (iniciar) begin
                    state_d = CARGA;
                    pal_d   = '0;
                    fila_d  = '0;
                end
            end
            CARGA: begin
                if (palabra_valida) begin
                    datos_d = palabra;
                    sel_d   = 2'd0;
                    state_d = EMITE;
                end
            end
            EMITE: begin
                if (ventana_lista) begin
                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                    end else begin
                        // Word exhausted: fetch the next one or close the row/image.
                        state_d = CARGA;
                        if (pal_q == C_ULT_PAL) begin
                            pal_d      = '0;
                            fin_fila_d = 1'b1;
                            if (fila_q == C_ULT_FILA) begin
                                fila_d       = '0;
                                fin_imagen_d = 1'b1;
                                state_d      = REPOSO;
                            end else begin
                                fila_d = fila_q + FW'(1);
                            end
                        end else begin
                            pal_d = pal_q + PW'(1);
                        end
                    end
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= REPOSO;
            datos_q      <= '0;
            sel_q        <= 2'd0;
            pal_q        <= '0;
            fila_q       <= '0;
            fin_fila_q   <= 1'b0;
            fin_imagen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            datos_q      <= datos_d;
            sel_q        <= sel_d;
            pal_q        <= pal_d;
            fila_q       <= fila_d;
            fin_fila_q   <= fin_fila_d;
            fin_imagen_q <= fin_imagen_d;
        end
    end

    assign palabra_lista  = (state_q == CARGA);
    assign ventana_valida = (state_q == EMITE);
    assign ocupado        = (state_q != REPOSO);
    assign datos          = datos_q;
    assign seleccion      = sel_q;
    assign fin_fila       = fin_fila_q;
    assign fin_imagen     = fin_imagen_q;

endmodule

`default_nettype wire

// File: tb/tb_control_divisor.sv
// ============================================================================
// Module      : tb_control_divisor
// Description : Scoreboard bench for control_divisor with random handshakes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_control_divisor;

    localparam int P = 2;
    localparam int F = 4;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  s;
        logic        ff;
        logic        fi;
    } win_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        iniciar;
    logic        palabra_valida;
    logic [63:0] palabra;
    logic        palabra_lista;
    logic [63:0] datos;
    logic [1:0]  seleccion;
    logic        ventana_valida;
    logic        ventana_lista;
    logic        fin_fila;
    logic        fin_imagen;
    logic        ocupado;

    logic        iniciar1 = 1'b0;
    logic        valid1   = 1'b0;
    logic [63:0] word1    = '0;
    logic        ready1   = 1'b0;
    logic        lista1, vv1, ff1, fi1, ocup1;
    logic [63:0] datos1;
    logic [1:0]  sel1;

    int   vectors = 0;
    int   errors  = 0;
    logic [63:0] src_q[$];
    win_t        exp_q[$];
    int   mode      = 2;   // 0: always ready/valid, 1: random, 2: quiet
    bit   mon_en    = 1'b0;
    bit   start_req = 1'b0;
    bit   noise_en  = 1'b0;

    always #5 clk = ~clk;

    control_divisor #(.PALABRAS_POR_FILA(P), .FILAS(F)) u_dut (
        .clk(clk), .reset_n(reset_n), .iniciar(iniciar),
        .palabra_valida(palabra_valida), .palabra(palabra),
        .palabra_lista(palabra_lista), .datos(datos), .seleccion(seleccion),
        .ventana_valida(ventana_valida), .ventana_lista(ventana_lista),
        .fin_fila(fin_fila), .fin_imagen(fin_imagen), .ocupado(ocupado)
    );

    control_divisor #(.PALABRAS_POR_FILA(1), .FILAS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .iniciar(iniciar1),
        .palabra_valida(valid1), .palabra(word1),
        .palabra_lista(lista1), .datos(datos1), .seleccion(sel1),
        .ventana_valida(vv1), .ventana_lista(ready1),
        .fin_fila(ff1), .fin_imagen(fi1), .ocupado(ocup1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an image is P*F words in order, each giving windows 0..3;
    // the last window of every P-th word closes a row, the very last the image.
    task automatic load_image(input bit fixed);
        logic [63:0] w;
        for (int i = 0; i < P * F; i++) begin
            if (fixed && i == 0)      w = 64'h0001020304050607;
            else if (fixed && i == 1) w = 64'h08090A0B0C0D0E0F;
            else                      w = {$urandom, $urandom};
            src_q.push_back(w);
            for (int s = 0; s < 4; s++)
                exp_q.push_back('{d: w, s: 2'(s),
                                  ff: (s == 3) && (i % P == P - 1),
                                  fi: (s == 3) && (i == P * F - 1)});
        end
    endtask

    // Source / sink driver
    initial begin : driver
        logic pl_s;
        iniciar = 1'b0; palabra_valida = 1'b0; palabra = '0; ventana_lista = 1'b0;
        forever begin
            @(negedge clk);
            pl_s = palabra_lista;
            @(posedge clk);
            #1;
            if (pl_s && palabra_valida && src_q.size() > 0) void'(src_q.pop_front());
            case (mode)
                0: begin
                    palabra_valida = (src_q.size() > 0);
                    ventana_lista  = 1'b1;
                end
                1: begin
                    palabra_valida = (src_q.size() > 0) && ($urandom % 4 != 0);
                    ventana_lista  = ($urandom % 3 != 0);
                end
                default: begin
                    palabra_valida = 1'b0;
                    ventana_lista  = 1'b0;
                end
            endcase
            palabra = (palabra_valida) ? src_q[0] : {$urandom, $urandom};
            iniciar = start_req || (noise_en && ocupado && ($urandom % 6 == 0));
            start_req = 1'b0;
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        bit   pend_ff, pend_fi, prev_vv, prev_acc;
        win_t e;
        pend_ff = 0; pend_fi = 0; prev_vv = 0; prev_acc = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pend_ff = 0; pend_fi = 0; prev_vv = 0; prev_acc = 0;
                continue;
            end
            chk("lista_and_valida", 64'(palabra_lista & ventana_valida), 64'd0);
            chk("fin_fila", 64'(fin_fila), 64'(pend_ff));
            chk("fin_imagen", 64'(fin_imagen), 64'(pend_fi));
            if (prev_vv && !prev_acc) chk("valida_held", 64'(ventana_valida), 64'd1);
            pend_ff = 0; pend_fi = 0;
            if (ventana_valida && ventana_lista) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("window_datos", datos, e.d);
                    chk("window_sel", 64'(seleccion), 64'(e.s));
                    pend_ff = e.ff;
                    pend_fi = e.fi;
                end
            end
            prev_vv  = ventana_valida;
            prev_acc = ventana_valida && ventana_lista;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_datos"}, datos, 64'd0);
        chk({tag, "_sel"}, 64'(seleccion), 64'd0);
        chk({tag, "_lista"}, 64'(palabra_lista), 64'd0);
        chk({tag, "_valida"}, 64'(ventana_valida), 64'd0);
        chk({tag, "_fin_fila"}, 64'(fin_fila), 64'd0);
        chk({tag, "_fin_imagen"}, 64'(fin_imagen), 64'd0);
        chk({tag, "_ocupado"}, 64'(ocupado), 64'd0);
    endtask

    task automatic run_image(input int budget);
        bit done = 0;
        start_req = 1'b1;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (fin_imagen) done = 1;
        end
        if (!done) chk("image_timeout", 64'd1, 64'd0);
        @(negedge clk);
        chk("image_windows_left", 64'(exp_q.size()), 64'd0);
        chk("image_end_ocupado", 64'(ocupado), 64'd0);
    endtask

    initial begin : main
        int  occ, pl, wins, fins, both;
        bit  done;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle");

        // Full-rate image with the two fixed leading words
        mon_en = 1'b1;
        noise_en = 1'b1;
        load_image(1);
        mode = 0;
        start_req = 1'b1;
        occ = 0; pl = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (ocupado) occ++;
            if (palabra_lista) pl++;
            if (fin_imagen) done = 1;
        end
        if (!done) chk("full_timeout", 64'd1, 64'd0);
        chk("full_busy_cycles", 64'(occ), 64'(P * F * 5));
        chk("full_lista_cycles", 64'(pl), 64'(P * F));
        @(negedge clk);
        chk("full_windows_left", 64'(exp_q.size()), 64'd0);
        chk("full_end_ocupado", 64'(ocupado), 64'd0);

        // Random handshakes, several images back to back
        mode = 1;
        for (int k = 0; k < 6; k++) begin
            load_image(0);
            run_image(3000);
        end

        // Reset abort in EMITE at seleccion 2
        load_image(0);
        start_req = 1'b1;
        done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (ventana_valida && seleccion == 2'd2) done = 1;
        end
        if (!done) chk("abort_timeout", 64'd1, 64'd0);
        mon_en = 1'b0;
        mode = 2;
        reset_n = 1'b0;
        #1;
        check_idle("abort");
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_fin", 64'({fin_fila, fin_imagen, ocupado}), 64'd0);
        end

        // Recovery after abort
        mon_en = 1'b1;
        mode = 1;
        load_image(0);
        run_image(3000);
        noise_en = 1'b0;
        mode = 2;

        // Single-word image instance
        word1  = {$urandom, $urandom};
        valid1 = 1'b1;
        ready1 = 1'b1;
        @(negedge clk);
        iniciar1 = 1'b1;
        @(negedge clk);
        iniciar1 = 1'b0;
        wins = 0; fins = 0; both = 0;
        for (int c = 0; c < 12; c++) begin
            if (vv1) begin
                chk("p1_datos", datos1, word1);
                chk("p1_sel", 64'(sel1), 64'(wins));
                wins++;
            end
            if (ff1 || fi1) begin
                fins++;
                if (ff1 && fi1) both++;
                chk("p1_end_ocupado", 64'(ocup1), 64'd0);
            end
            @(negedge clk);
        end
        chk("p1_windows", 64'(wins), 64'd4);
        chk("p1_fin_cycles", 64'(fins), 64'd1);
        chk("p1_fin_together", 64'(both), 64'd1);
        chk("p1_idle", 64'(ocup1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
